fetch_controller: RTL and testbench

// Sequences the single-port, combinational-read instruction memory for the core front end.

---
 rtl/fetch_controller_if.sv | 26 ++
 rtl/fetch_controller.sv | 143 ++++++++++++++
 tb/tb_fetch_controller.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_controller_if.sv
// Bus bundle between the fetch controller, instruction memory, redirect source and decode.
// dec_valid/dec_ready: a transfer happens on a rising edge where both are high; valid never depends on ready.
interface fetch_controller_if;
  logic        enable;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        dec_valid;
  logic        dec_ready;
  logic [31:0] dec_instr;
  logic [31:0] dec_pc;
  logic        busy;
  logic        fault;
  logic [31:0] fault_pc;

  modport master (
    input  enable, imem_instr, redirect_valid, redirect_pc, dec_ready,
    output imem_addr, dec_valid, dec_instr, dec_pc, busy, fault, fault_pc
  );

  modport slave (
    output enable, imem_instr, redirect_valid, redirect_pc, dec_ready,
    input  imem_addr, dec_valid, dec_instr, dec_pc, busy, fault, fault_pc
  );
endinterface

// File: rtl/fetch_controller.sv
// Front-end fetch sequencer: owns the PC, reads the combinational imem and queues
// {instr, pc} pairs toward decode; handles redirect flushes, drain and sticky faults.
module fetch_controller #(
  parameter logic [31:0] RESET_PC   = 32'h0,
  parameter int          IMEM_DEPTH = 256,
  parameter int          BUF_DEPTH  = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  fetch_controller_if.master bus,
  output logic [1:0]         dbg_state
);
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_FAULT = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      instr_q [BUF_DEPTH];
  logic [31:0]      instr_d [BUF_DEPTH];
  logic [31:0]      epc_q [BUF_DEPTH];
  logic [31:0]      epc_d [BUF_DEPTH];
  logic [31:0]      hold_instr_q, hold_instr_d;
  logic [31:0]      hold_pc_q, hold_pc_d;
  logic             fault_q, fault_d;
  logic [31:0]      fault_pc_q, fault_pc_d;

  logic full, empty, pc_legal, pop, redir, redir_bad, flush;
  logic fetch_opp, push, range_fault;
  logic [31:0] head_instr, head_pc;

  always_comb begin
    full        = (count_q == CNT_W'(BUF_DEPTH));
    empty       = (count_q == '0);
    pc_legal    = ({2'b00, pc_q[31:2]} < 32'(IMEM_DEPTH));
    pop         = !empty && bus.dec_ready;
    redir       = bus.redirect_valid && (state_q != S_FAULT);
    redir_bad   = redir && (bus.redirect_pc[1:0] != 2'b00);
    flush       = redir && !redir_bad;
    // A full FIFO still offers a slot when decode drains the head this cycle.
    fetch_opp   = (state_q == S_RUN) && !bus.redirect_valid && (!full || pop);
    range_fault = fetch_opp && !pc_legal;
    push        = fetch_opp && pc_legal;
    head_instr  = empty ? hold_instr_q : instr_q[rd_ptr_q];
    head_pc     = empty ? hold_pc_q    : epc_q[rd_ptr_q];
  end

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    instr_d      = instr_q;
    epc_d        = epc_q;
    hold_instr_d = head_instr;
    hold_pc_d    = head_pc;
    fault_d      = fault_q;
    fault_pc_d   = fault_pc_q;

    case (state_q)
      S_IDLE:  if (bus.enable) state_d = S_RUN;
      S_RUN:   if (!bus.enable) state_d = S_DRAIN;
      S_DRAIN: begin
        if (bus.enable)          state_d = S_RUN;
        else if (empty || flush) state_d = S_IDLE;
      end
      default: state_d = state_q;
    endcase

    if (flush) begin
      pc_d     = bus.redirect_pc;
      rd_ptr_d = wr_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        instr_d[wr_ptr_q] = bus.imem_instr;
        epc_d[wr_ptr_q]   = pc_q;
        wr_ptr_d          = wr_ptr_q + PTR_W'(1);
        pc_d              = pc_q + 32'd4;
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // Faults freeze the PC but leave buffered entries for decode to drain.
    if (redir_bad) begin
      state_d    = S_FAULT;
      fault_d    = 1'b1;
      fault_pc_d = bus.redirect_pc;
    end else if (range_fault) begin
      state_d    = S_FAULT;
      fault_d    = 1'b1;
      fault_pc_d = pc_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      fault_q      <= 1'b0;
      fault_pc_q   <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        instr_q[i] <= '0;
        epc_q[i]   <= '0;
      end
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      hold_instr_q <= hold_instr_d;
      hold_pc_q    <= hold_pc_d;
      fault_q      <= fault_d;
      fault_pc_q   <= fault_pc_d;
      instr_q      <= instr_d;
      epc_q        <= epc_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.dec_valid = !empty;
  assign bus.dec_instr = head_instr;
  assign bus.dec_pc    = head_pc;
  assign bus.busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign bus.fault     = fault_q;
  assign bus.fault_pc  = fault_pc_q;
  assign dbg_state     = state_q;
endmodule

// File: tb/tb_fetch_controller.sv
// Randomized bench for fetch_controller: a queue-based reference model predicts decode
// traffic; a negedge monitor pops and compares while the driver runs on the posedge side.
module tb_fetch_controller;
  localparam int DEPTH = 256;
  localparam int BUF   = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;
  localparam int M_FAULT = 3;

  logic clk;
  logic reset_n;
  logic [1:0] dbg_state;
  fetch_controller_if bus();

  fetch_controller #(.RESET_PC(32'h0), .IMEM_DEPTH(DEPTH), .BUF_DEPTH(BUF)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- memory image ----------------
  logic [31:0] mem [DEPTH];

  function automatic logic [31:0] word_at(input logic [31:0] a);
    if (a[31:10] == 22'd0) return mem[a[9:2]];
    return {16'hBAD0, a[15:0]};
  endfunction

  assign bus.imem_instr = word_at(bus.imem_addr);

  // ---------------- reference model state ----------------
  logic [63:0] exp_q[$];
  int          m_mode;
  logic [31:0] m_pc, m_fpc;
  bit          m_fault;
  logic [31:0] last_pc, last_instr;
  bit          chk_en;
  int          n_vec, n_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_mode     = M_IDLE;
    m_pc       = 32'h0;
    m_fpc      = 32'h0;
    m_fault    = 1'b0;
    last_pc    = 32'h0;
    last_instr = 32'h0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("dec_valid", {31'd0, bus.dec_valid}, {31'd0, exp_q.size() != 0});
      if (exp_q.size() != 0) begin
        check("dec_pc", bus.dec_pc, exp_q[0][31:0]);
        check("dec_instr", bus.dec_instr, exp_q[0][63:32]);
        last_pc    = exp_q[0][31:0];
        last_instr = exp_q[0][63:32];
        if (bus.dec_ready) void'(exp_q.pop_front());
      end else begin
        check("dec_pc_hold", bus.dec_pc, last_pc);
        check("dec_instr_hold", bus.dec_instr, last_instr);
      end
      check("imem_addr", bus.imem_addr, m_pc);
      check("busy", {31'd0, bus.busy}, {31'd0, (m_mode == M_RUN) || (m_mode == M_DRAIN)});
      check("fault", {31'd0, bus.fault}, {31'd0, m_fault});
      if (m_fault) check("fault_pc", bus.fault_pc, m_fpc);
    end
  end

  // ---------------- driver + model step ----------------
  task automatic cycle(input bit en, input bit rv, input logic [31:0] rpc, input bit rdy);
    bit pop, space, do_flush, do_push, nf;
    int nm;
    logic [31:0] npc, nfpc;
    logic [63:0] entry;
    bus.enable         = en;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
    bus.dec_ready      = rdy;

    pop      = (exp_q.size() != 0) && rdy;
    space    = (exp_q.size() < BUF) || pop;
    nm       = m_mode;
    npc      = m_pc;
    nf       = m_fault;
    nfpc     = m_fpc;
    do_flush = 1'b0;
    do_push  = 1'b0;
    entry    = 64'd0;
    if (m_mode != M_FAULT) begin
      if (rv && (rpc[1:0] != 2'b00)) begin
        nm   = M_FAULT;
        nf   = 1'b1;
        nfpc = rpc;
      end else begin
        if (rv) begin
          do_flush = 1'b1;
          npc      = rpc;
        end else if (m_mode == M_RUN && space) begin
          if ((m_pc >> 2) < DEPTH) begin
            do_push = 1'b1;
            entry   = {word_at(m_pc), m_pc};
            npc     = m_pc + 32'd4;
          end else begin
            nf   = 1'b1;
            nfpc = m_pc;
          end
        end
        if (m_mode == M_IDLE && en) nm = M_RUN;
        else if (m_mode == M_RUN && !en) nm = M_DRAIN;
        else if (m_mode == M_DRAIN) begin
          if (en) nm = M_RUN;
          else if (exp_q.size() == 0 || do_flush) nm = M_IDLE;
        end
        if (nf) nm = M_FAULT;
      end
    end

    @(posedge clk);
    #1;
    if (do_flush) exp_q.delete();
    if (do_push) exp_q.push_back(entry);
    m_mode  = nm;
    m_pc    = npc;
    m_fault = nf;
    m_fpc   = nfpc;
  endtask

  task automatic do_reset();
    chk_en             = 1'b0;
    bus.enable         = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.dec_ready      = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_imem_addr", bus.imem_addr, 32'h0);
    check("rst_dec_valid", {31'd0, bus.dec_valid}, 32'd0);
    check("rst_dec_instr", bus.dec_instr, 32'h0);
    check("rst_dec_pc", bus.dec_pc, 32'h0);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_fault", {31'd0, bus.fault}, 32'd0);
    check("rst_fault_pc", bus.fault_pc, 32'h0);
    model_reset();
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk_en = 1'b1;
  endtask

  function automatic logic [31:0] rand_target();
    int r;
    r = $urandom_range(0, 99);
    if (r < 70) return 32'($urandom_range(0, DEPTH - 1)) << 2;
    if (r < 90) return 32'h3F0 + (32'($urandom_range(0, 3)) << 2);
    return 32'h400 + (32'($urandom_range(0, 3)) << 2);
  endfunction

  task automatic rand_phase(input int n, input int en_pct, input int rdy_pct,
                            input int rv_pct, input int bad_pct);
    logic [31:0] t;
    bit en, rv, rdy;
    for (int i = 0; i < n; i++) begin
      en  = ($urandom_range(0, 99) < en_pct);
      rdy = ($urandom_range(0, 99) < rdy_pct);
      rv  = ($urandom_range(0, 99) < rv_pct);
      t   = rand_target();
      if (rv && ($urandom_range(0, 99) < bad_pct)) t = t | 32'($urandom_range(1, 3));
      cycle(en, rv, t, rdy);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_vec   = 0;
    n_err   = 0;
    chk_en  = 1'b0;
    reset_n = 1'b1;
    for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
    model_reset();
    do_reset();

    repeat (8) cycle(1, 0, 32'h0, 1);
    repeat (5) cycle(1, 0, 32'h0, 0);
    repeat (6) cycle(1, 0, 32'h0, 1);

    repeat (3) cycle(1, 0, 32'h0, 0);
    cycle(1, 1, 32'h40, 0);
    repeat (4) cycle(1, 0, 32'h0, 1);

    repeat (3) cycle(1, 0, 32'h0, 0);
    repeat (2) cycle(0, 0, 32'h0, 0);
    repeat (4) cycle(0, 0, 32'h0, 1);
    repeat (4) cycle(1, 0, 32'h0, 1);

    rand_phase(300, 85, 70, 5, 0);

    cycle(1, 1, 32'h3F0, 1);
    repeat (12) cycle(1, 0, 32'h0, 1);
    rand_phase(10, 80, 60, 30, 30);

    do_reset();
    repeat (2) cycle(1, 0, 32'h0, 1);
    repeat (4) cycle(1, 0, 32'h0, 0);
    do_reset();

    repeat (3) cycle(1, 0, 32'h0, 1);
    cycle(1, 1, 32'h42, 0);
    rand_phase(8, 80, 50, 40, 0);
    do_reset();

    for (int s = 0; s < 4; s++) begin
      rand_phase(250, 80, 60, 4, 3);
      do_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
